// File: rtl/wb_glitch_gen.sv
// Wishbone-programmable glitch pulse generator: delay, width, gap and count are
// set by firmware; a sequence starts from a CTRL write or a synchronised trigger edge.
module wb_glitch_gen #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
    parameter int unsigned DELAY_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        trig_i,
    output logic        glitch,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_GAP} state_t;

    state_t             r_state, w_state_nx;
    logic [DELAY_W-1:0] r_cnt, w_cnt_nx;
    logic [DELAY_W-1:0] r_delay, r_gap, w_width_m1, w_gap_m1;
    logic [7:0]         r_width, r_count, r_pd, w_pd_nx, w_pd_inc, w_count_eff;
    logic               r_glitch, w_glitch_nx;
    logic               r_done, w_done_nx, r_aborted, w_aborted_nx;
    logic               r_ext_en;
    logic [1:0]         r_sync;
    logic               r_sync_d;
    logic               r_ack;
    logic [31:0]        r_rdata, w_rmux;
    logic               w_acc, w_wr, w_rd, w_ctrl_wr, w_start, w_abort, w_idle, w_trig_ev;
    logic [2:0]         w_reg;
    logic               w_unused;

    assign w_acc     = i_wb_cyc & i_wb_stb & (i_wb_addr[31:5] == BASE_ADDRESS[31:5]);
    assign w_wr      = w_acc & i_wb_we;
    assign w_rd      = w_acc & ~i_wb_we;
    assign w_reg     = i_wb_addr[4:2];
    assign w_ctrl_wr = w_wr & (w_reg == 3'd0);
    assign w_idle    = (r_state == S_IDLE);
    // abort takes priority over start when both bits arrive in one write
    assign w_start   = w_ctrl_wr & i_wb_data[0] & ~i_wb_data[2];
    assign w_abort   = w_ctrl_wr & i_wb_data[2];
    assign w_trig_ev = r_ext_en & w_idle & r_sync[1] & ~r_sync_d;

    // Zero-valued WIDTH/GAP/COUNT behave as 1; counters hold "cycles remaining minus one".
    assign w_width_m1  = (r_width == 8'd0) ? '0 : DELAY_W'(r_width - 8'd1);
    assign w_gap_m1    = (r_gap == '0) ? '0 : r_gap - DELAY_W'(1);
    assign w_count_eff = (r_count == 8'd0) ? 8'd1 : r_count;
    assign w_pd_inc    = (r_pd == 8'hFF) ? 8'hFF : r_pd + 8'd1;

    assign busy       = ~w_idle;
    assign glitch     = r_glitch;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_wb_stall = 1'b0;
    assign w_unused   = &{1'b0, i_wb_addr[1:0], i_wb_data};

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_glitch_nx  = r_glitch;
        w_pd_nx      = r_pd;
        w_done_nx    = r_done;
        w_aborted_nx = r_aborted;
        case (r_state)
            S_IDLE: begin
                w_glitch_nx = 1'b0;
                if (w_start || w_trig_ev) begin
                    w_state_nx   = S_DELAY;
                    w_cnt_nx     = r_delay;
                    w_done_nx    = 1'b0;
                    w_aborted_nx = 1'b0;
                    w_pd_nx      = 8'd0;
                end
            end
            S_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nx  = S_PULSE;
                    w_glitch_nx = 1'b1;
                    w_cnt_nx    = w_width_m1;
                end else begin
                    w_cnt_nx = r_cnt - DELAY_W'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_glitch_nx = 1'b0;
                    w_pd_nx     = w_pd_inc;
                    if (w_pd_inc == w_count_eff) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_GAP;
                        w_cnt_nx   = w_gap_m1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - DELAY_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx  = S_PULSE;
                    w_glitch_nx = 1'b1;
                    w_cnt_nx    = w_width_m1;
                end else begin
                    w_cnt_nx = r_cnt - DELAY_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_abort && !w_idle) begin
            w_state_nx   = S_IDLE;
            w_glitch_nx  = 1'b0;
            w_aborted_nx = 1'b1;
            w_done_nx    = 1'b0;
            w_pd_nx      = r_pd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_glitch  <= 1'b0;
            r_pd      <= 8'd0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_glitch  <= w_glitch_nx;
            r_pd      <= w_pd_nx;
            r_done    <= w_done_nx;
            r_aborted <= w_aborted_nx;
        end
    end

    always_comb begin
        w_rmux = '0;
        case (w_reg)
            3'd0:    w_rmux[1] = r_ext_en;
            3'd1:    w_rmux[DELAY_W-1:0] = r_delay;
            3'd2:    w_rmux[7:0] = r_width;
            3'd3:    w_rmux[DELAY_W-1:0] = r_gap;
            3'd4:    w_rmux[7:0] = r_count;
            3'd5:    w_rmux = {16'b0, r_pd, 5'b0, r_aborted, r_done, busy};
            default: w_rmux = '0;
        endcase
    end

    // Timing parameters are frozen while a sequence runs; ext_en is always writable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_delay  <= '0;
            r_width  <= 8'd0;
            r_gap    <= '0;
            r_count  <= 8'd0;
            r_ext_en <= 1'b0;
            r_ack    <= 1'b0;
            r_rdata  <= 32'd0;
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
        end else begin
            r_ack    <= w_acc;
            r_rdata  <= w_rd ? w_rmux : 32'd0;
            r_sync   <= {r_sync[0], trig_i};
            r_sync_d <= r_sync[1];
            if (w_ctrl_wr) begin
                r_ext_en <= i_wb_data[1];
            end
            if (w_wr && w_idle) begin
                case (w_reg)
                    3'd1:    r_delay <= i_wb_data[DELAY_W-1:0];
                    3'd2:    r_width <= i_wb_data[7:0];
                    3'd3:    r_gap   <= i_wb_data[DELAY_W-1:0];
                    3'd4:    r_count <= i_wb_data[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_glitch_gen.sv
// Self-checking bench for wb_glitch_gen: cycle-exact glitch/busy patterns and
// register reads scored against an expected-data queue.
module tb_wb_glitch_gen;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk;
    logic        reset_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack, o_wb_stall;
    logic [31:0] o_wb_data;
    logic        trig_i;
    logic        glitch, busy;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    wb_glitch_gen #(.BASE_ADDRESS(BASE), .DELAY_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .trig_i     (trig_i),
        .glitch     (glitch),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drivers start on a falling edge; the next rising edge is the accept edge.
    task automatic wb_write(input logic [7:0] off, input logic [31:0] data);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = BASE + 32'(off);
        i_wb_data = data;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        check($sformatf("wr_ack_%02h", off), 32'(o_wb_ack), 32'd1);
        check($sformatf("wr_data_zero_%02h", off), o_wb_data, 32'd0);
    endtask

    task automatic wb_read(input logic [7:0] off, input logic [31:0] exp);
        exp_q.push_back(exp);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = BASE + 32'(off);
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        check($sformatf("rd_ack_%02h", off), 32'(o_wb_ack), 32'd1);
        if (o_wb_ack && exp_q.size() > 0)
            check($sformatf("rd_data_%02h", off), o_wb_data, exp_q.pop_front());
    endtask

    // Bit k-1 of each vector is the value expected just after the k-th edge following the accept edge.
    task automatic expect_seq(input string tag, input int n, input logic [31:0] g_exp, input logic [31:0] b_exp);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check($sformatf("%s_glitch_e%0d", tag, k), 32'(glitch), 32'(g_exp[k-1]));
            check($sformatf("%s_busy_e%0d", tag, k), 32'(busy), 32'(b_exp[k-1]));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = 32'd0;
        i_wb_data = 32'd0;
        trig_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_glitch", 32'(glitch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(o_wb_ack), 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single pulse after a delay
        wb_write(8'h04, 32'd3);
        wb_write(8'h08, 32'd2);
        wb_write(8'h10, 32'd1);
        wb_write(8'h00, 32'h1);
        check("t1_busy_start", 32'(busy), 32'd1);
        expect_seq("t1", 7, 32'h18, 32'h1F);
        wb_read(8'h14, 32'h0000_0102);

        // reserved write acks once and is ignored
        wb_write(8'h18, 32'hFFFF_FFFF);
        @(negedge clk);
        check("ack_one_cycle", 32'(o_wb_ack), 32'd0);
        wb_read(8'h18, 32'd0);

        // pulse train with gaps
        wb_write(8'h04, 32'd0);
        wb_write(8'h08, 32'd1);
        wb_write(8'h0C, 32'd2);
        wb_write(8'h10, 32'd3);
        wb_write(8'h00, 32'h1);
        expect_seq("t2", 9, 32'h49, 32'h7F);
        wb_read(8'h14, 32'h0000_0302);

        // zero width/gap/count behave as 1
        wb_write(8'h08, 32'd0);
        wb_write(8'h0C, 32'd0);
        wb_write(8'h10, 32'd0);
        wb_write(8'h00, 32'h1);
        expect_seq("t3", 3, 32'h1, 32'h1);
        wb_read(8'h14, 32'h0000_0102);

        // trigger ignored while ext_en is clear
        trig_i = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_noext_busy", 32'(busy), 32'd0);
        trig_i = 1'b0;
        repeat (3) @(negedge clk);

        // external trigger; a second edge while busy adds nothing
        wb_write(8'h04, 32'd5);
        wb_write(8'h08, 32'd1);
        wb_write(8'h10, 32'd1);
        wb_write(8'h00, 32'h2);
        trig_i = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            @(negedge clk);
            check($sformatf("t4_glitch_m%0d", m), 32'(glitch), 32'(m == 9));
            check($sformatf("t4_busy_m%0d", m), 32'(busy), 32'(m >= 3 && m <= 9));
            if (m == 4) trig_i = 1'b0;
            if (m == 6) trig_i = 1'b1;
        end
        trig_i = 1'b0;
        repeat (3) @(negedge clk);
        wb_read(8'h00, 32'h0000_0002);
        wb_write(8'h00, 32'h0);
        wb_read(8'h14, 32'h0000_0102);

        // abort during the second pulse
        wb_write(8'h04, 32'd0);
        wb_write(8'h08, 32'd4);
        wb_write(8'h10, 32'd10);
        wb_write(8'h00, 32'h1);
        expect_seq("t5", 6, 32'h2F, 32'h3F);
        wb_write(8'h00, 32'h4);
        check("t5_glitch_abort", 32'(glitch), 32'd0);
        check("t5_busy_abort", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t5_quiet", 32'(glitch), 32'd0);
        wb_read(8'h14, 32'h0000_0104);
        wb_write(8'h00, 32'h5);
        check("t5_start_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_start_abort_glitch", 32'(glitch), 32'd0);
        wb_read(8'h14, 32'h0000_0104);

        // writes while busy are ignored
        wb_write(8'h04, 32'd20);
        wb_write(8'h08, 32'd1);
        wb_write(8'h10, 32'd1);
        wb_write(8'h00, 32'h1);
        wb_write(8'h04, 32'd7);
        wb_read(8'h04, 32'd20);
        wait_idle(100);
        wb_read(8'h14, 32'h0000_0102);

        // asynchronous reset in the middle of a pulse
        wb_write(8'h04, 32'd0);
        wb_write(8'h08, 32'd8);
        wb_write(8'h00, 32'h1);
        repeat (2) @(negedge clk);
        check("t6_glitch_high", 32'(glitch), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_glitch", 32'(glitch), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 7; r++) wb_read(8'(r * 4), 32'd0);

        // out-of-window access gets no ack
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = BASE + 32'h20;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        check("oow_no_ack", 32'(o_wb_ack), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_glitch_gen.md
Name: wb_glitch_gen

Overview:
Wishbone-programmable glitch pulse generator that drives the `glitch` test input of the hoggephase alarm block directly upstream of it. Firmware configures delay, pulse width, inter-pulse gap and pulse count. A sequence starts from a software write or from an external trigger pin. The block produces cycle-exact pulses so the detector's alarm, latch and counter response can be characterised.

Parameters:
BASE_ADDRESS, 32'h3000_0100, base of the 8-word register window (byte addresses, word-aligned).
DELAY_W, 16, width of the DELAY and GAP registers.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_wb_cyc  input  1  wishbone cycle
i_wb_stb  input  1  wishbone strobe
i_wb_we  input  1  write enable
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data
o_wb_ack  output  1  one-cycle acknowledge
o_wb_stall  output  1  tied 0
o_wb_data  output  32  read data, 0 when not acking a read
trig_i  input  1  asynchronous external trigger (gpio)
glitch  output  1  registered glitch pulse to the alarm block
busy  output  1  sequence in progress

Behaviour:
- Reset: clk, async active-low reset_n. All registers, FSM, o_wb_ack, o_wb_data, glitch and busy are cleared immediately on reset_n low. Deassertion is synchronous use only.
- Register map (offset: field):
  - 0x00 CTRL (W): bit0 start (self-clearing), bit1 ext_en, bit2 abort (self-clearing). Reads return {30'b0, ext_en, 1'b0}.
  - 0x04 DELAY[DELAY_W-1:0].
  - 0x08 WIDTH[7:0].
  - 0x0C GAP[DELAY_W-1:0].
  - 0x10 COUNT[7:0].
  - 0x14 STATUS (R): {16'b0, pulses_done[7:0], 5'b0, aborted, done, busy}.
  - 0x18–0x1C: reserved. Reads return 0; writes are ignored.
- Wishbone access:
  - A transaction is accepted when cyc & stb and i_wb_addr[31:5] == BASE_ADDRESS[31:5].
  - o_wb_ack pulses high exactly 1 cycle after the accept edge. Read data is valid with the ack.
  - Addresses outside the window get no ack.
- Write rules while busy:
  - Writes to DELAY, WIDTH, GAP, COUNT and to start are ignored.
  - abort and ext_en are honoured.
- Zero-value rules: WIDTH=0, GAP=0 and COUNT=0 are each treated as 1.
- Trigger path: trig_i passes through a 2-flop synchroniser, then rising-edge detection. This is a trigger event only when ext_en=1 and FSM is IDLE.
- FSM states: IDLE, DELAY, PULSE, GAP.
  - IDLE → DELAY on start write or trigger event. Load the delay counter with DELAY. Clear done, aborted and pulses_done. busy=1.
  - DELAY: decrement. When the counter is 0, go to PULSE.
  - Timing: with a software start accepted on edge E0, glitch rises at edge E0+DELAY+1.
  - PULSE: glitch=1 for exactly WIDTH cycles. Then increment pulses_done.
    - If pulses_done == COUNT, go to IDLE with done=1, busy=0.
    - Otherwise go to GAP.
  - GAP: glitch=0 for exactly GAP cycles, then go to PULSE.
- Trigger latency: for a trigger event, the first glitch rises DELAY+3 cycles after the first clk edge at which trig_i is sampled high.
- abort in any non-IDLE state:
  - glitch=0 on the edge after the write is accepted; FSM goes to IDLE.
  - aborted=1, done stays 0, pulses_done holds its value.
  - abort in IDLE has no effect.
- start and abort in the same write: abort wins, no sequence starts.
- start while busy: ignored, no restart.
- pulses_done: 8-bit, saturates at 255. Maximum COUNT is 255, so it never wraps in normal operation.
- Counters are DELAY_W bits wide and never underflow. The zero check happens before decrement.
- glitch is a flop output, glitch-free and never combinational.
- Asynchronous reset mid-sequence: glitch drops immediately and all state clears.

Test Plan:
1. Reset, then DELAY=3, WIDTH=2, COUNT=1, write start at edge E0 → glitch high at edges E0+4..E0+5 only; STATUS reads 0x0000_0102 (pulses_done=1, done=1).
2. DELAY=0, WIDTH=1, GAP=2, COUNT=3, start → glitch pattern 1,0,0,1,0,0,1 from E0+1; busy drops the cycle after the last pulse; pulses_done=3.
3. WIDTH=0, GAP=0, COUNT=0, start → a single 1-cycle pulse; done=1.
4. ext_en=1, DELAY=5, raise trig_i → glitch rises 8 cycles after trig is first sampled; a second trig edge while busy produces no extra pulses.
5. COUNT=10, WIDTH=4, abort during the 2nd pulse → glitch low on the next edge; STATUS aborted=1, done=0, pulses_done=1.
6. Write DELAY=7 while busy, read back → old value retained. Assert reset_n low mid-pulse → glitch=0 asynchronously and all registers read 0 after release.
